// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch read-only, load/store read/write) in front of a
// single DLX memory port; serialises accesses and returns one registered response each.
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 32,
    parameter int ADDRESS_SIZE = 16,
    parameter int TIMEOUT      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [ADDRESS_SIZE-1:0] i_addr,
    output logic                    i_ack,
    output logic [WORD_SIZE-1:0]    i_rdata,
    output logic                    i_err,
    input  logic                    d_req,
    input  logic                    d_rnw,
    input  logic [ADDRESS_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0]    d_wdata,
    output logic                    d_ack,
    output logic [WORD_SIZE-1:0]    d_rdata,
    output logic                    d_err,
    output logic                    mem_en,
    output logic                    mem_rnw,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]    mem_wdata,
    input  logic [WORD_SIZE-1:0]    mem_rdata,
    input  logic                    mem_ready
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_t;

    typedef struct packed {
        gnt_t                    gnt;
        logic                    rnw;
        logic [ADDRESS_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0]    wdata;
    } access_t;

    typedef struct packed {
        logic [WORD_SIZE-1:0] rdata;
        logic                 err;
    } resp_t;

    state_t     state_q, state_d;
    gnt_t       last_q, last_d;
    gnt_t       pick;
    access_t    acc_q, acc_d;
    resp_t      rsp_q, rsp_d;
    resp_t      i_rsp_q, i_rsp_d;
    resp_t      d_rsp_q, d_rsp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       mem_en_q, mem_en_d;
    logic       i_ack_q, i_ack_d;
    logic       d_ack_q, d_ack_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_q   <= GNT_D;
            acc_q    <= '0;
            rsp_q    <= '0;
            i_rsp_q  <= '0;
            d_rsp_q  <= '0;
            cnt_q    <= '0;
            mem_en_q <= 1'b0;
            i_ack_q  <= 1'b0;
            d_ack_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            acc_q    <= acc_d;
            rsp_q    <= rsp_d;
            i_rsp_q  <= i_rsp_d;
            d_rsp_q  <= d_rsp_d;
            cnt_q    <= cnt_d;
            mem_en_q <= mem_en_d;
            i_ack_q  <= i_ack_d;
            d_ack_q  <= d_ack_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        acc_d    = acc_q;
        rsp_d    = rsp_q;
        i_rsp_d  = i_rsp_q;
        d_rsp_d  = d_rsp_q;
        cnt_d    = cnt_q;
        mem_en_d = mem_en_q;
        i_ack_d  = 1'b0;
        d_ack_d  = 1'b0;
        // On a tie the side that did not win last time gets the port
        if (i_req && d_req) pick = (last_q == GNT_D) ? GNT_I : GNT_D;
        else                pick = d_req ? GNT_D : GNT_I;

        case (state_q)
            IDLE: begin
                mem_en_d = 1'b0;
                if (i_req || d_req) begin
                    acc_d.gnt = pick;
                    if (pick == GNT_I) begin
                        acc_d.rnw   = 1'b1;
                        acc_d.addr  = i_addr;
                        acc_d.wdata = '0;
                    end else begin
                        acc_d.rnw   = d_rnw;
                        acc_d.addr  = d_addr;
                        acc_d.wdata = d_wdata;
                    end
                    mem_en_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // Ready is checked before the watchdog so a late ready still wins
                if (mem_ready) begin
                    rsp_d.rdata = acc_q.rnw ? mem_rdata : '0;
                    rsp_d.err   = 1'b0;
                    mem_en_d    = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_d.rdata = '0;
                    rsp_d.err   = 1'b1;
                    mem_en_d    = 1'b0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                mem_en_d = 1'b0;
                if (acc_q.gnt == GNT_I) begin
                    i_ack_d = 1'b1;
                    i_rsp_d = rsp_q;
                end else begin
                    d_ack_d = 1'b1;
                    d_rsp_d = rsp_q;
                end
                last_d  = acc_q.gnt;
                state_d = IDLE;
            end
            default: begin
                mem_en_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign mem_en    = mem_en_q;
    assign mem_rnw   = acc_q.rnw;
    assign mem_addr  = acc_q.addr;
    assign mem_wdata = acc_q.wdata;
    assign i_ack     = i_ack_q;
    assign i_rdata   = i_rsp_q.rdata;
    assign i_err     = i_rsp_q.err;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rsp_q.rdata;
    assign d_err     = d_rsp_q.err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single accesses plus
// hand sequences for round-robin contention and reset during an access.
module tb_mem_port_arbiter;

    logic        clk, rst;
    logic        i_req, i_ack, i_err;
    logic [15:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_req, d_rnw, d_ack, d_err;
    logic [15:0] d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        mem_en, mem_rnw, mem_ready;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [logic [15:0]];

    mem_port_arbiter #(.WORD_SIZE(32), .ADDRESS_SIZE(16), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_rnw(d_rnw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_rnw(mem_rnw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          rnw;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          ready_cyc;   // BUSY cycle on which ready is raised; 0 = never
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;     // edges from grant to ack
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic do_access(input vec_t v, input string tag);
        int          cyc;
        bit          got;
        int          other_acks;
        logic [32:0] other_hold;
        cyc = 0; got = 0; other_acks = 0;
        other_hold = v.is_d ? {i_rdata, i_err} : {d_rdata, d_err};
        if (v.is_d) begin
            d_req = 1'b1; d_rnw = v.rnw; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        @(posedge clk); #1;
        chk({tag, "_en"},    mem_en, 1);
        chk({tag, "_rnw"},   mem_rnw, v.is_d ? v.rnw : 1'b1);
        chk({tag, "_addr"},  mem_addr, v.addr);
        chk({tag, "_wdata"}, mem_wdata, v.is_d ? v.wdata : 32'h0);
        while (!got && cyc < 40) begin
            cyc++;
            mem_ready = (cyc == v.ready_cyc);
            mem_rdata = mem_ready && v.rnw ? mem_rd(v.addr) : $urandom;
            @(posedge clk); #1;
            if (mem_ready && v.is_d && !v.rnw) mem[v.addr] = v.wdata;
            mem_ready = 1'b0;
            if (v.is_d ? i_ack : d_ack) other_acks++;
            if (v.is_d ? d_ack : i_ack) got = 1;
        end
        chk({tag, "_ack_seen"}, got, 1);
        chk({tag, "_lat"},   cyc, v.exp_lat);
        chk({tag, "_rdata"}, v.is_d ? d_rdata : i_rdata, v.exp_rdata);
        chk({tag, "_err"},   v.is_d ? d_err : i_err, v.exp_err);
        chk({tag, "_en_gap"}, mem_en, 0);
        chk({tag, "_other_ack"}, other_acks, 0);
        chk({tag, "_other_hold"}, v.is_d ? {i_rdata, i_err} : {d_rdata, d_err}, other_hold);
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_ack_pulse"}, {i_ack, d_ack}, 2'b00);
    endtask

    vec_t vecs[8];

    initial begin
        int rr_w;
        bit rr_d;
        vecs[0] = '{0, 1, 16'h0010, 32'h0,        1,  32'h20010004, 0, 2};
        vecs[1] = '{1, 0, 16'h0100, 32'hDEADBEEF, 1,  32'h0,        0, 2};
        vecs[2] = '{1, 1, 16'h0100, 32'h0,        3,  32'hDEADBEEF, 0, 4};
        vecs[3] = '{1, 1, 16'h0200, 32'h0,        0,  32'h0,        1, 17};
        vecs[4] = '{0, 1, 16'h0010, 32'h0,        2,  32'h20010004, 0, 3};
        vecs[5] = '{0, 1, 16'h0020, 32'h0,        16, 32'h12345678, 0, 17};
        vecs[6] = '{1, 0, 16'h0020, 32'hCAFEF00D, 0,  32'h0,        1, 17};
        vecs[7] = '{0, 1, 16'h0020, 32'h0,        1,  32'h12345678, 0, 2};
        mem[16'h0010] = 32'h20010004;
        mem[16'h0020] = 32'h12345678;

        rst = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_rnw = 0; d_addr = 0; d_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
        #12;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_bus", {mem_rnw, mem_addr, mem_wdata}, 0);
        chk("rst_i_out", {i_ack, i_rdata, i_err}, 0);
        chk("rst_d_out", {d_ack, d_rdata, d_err}, 0);
        @(negedge clk); rst = 1'b1;

        for (int k = 0; k < 8; k++) do_access(vecs[k], $sformatf("vec%0d", k));

        // Contention straight after reset: expect I, D, I, D
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        i_req = 1'b1; i_addr = 16'h0010;
        d_req = 1'b1; d_rnw = 1'b1; d_addr = 16'h0100;
        for (int k = 0; k < 4; k++) begin
            rr_d = (k % 2) == 1;
            rr_w = 0;
            while (!mem_en && rr_w < 10) begin @(posedge clk); #1; rr_w++; end
            chk($sformatf("rr%0d_grant", k), mem_addr, rr_d ? 16'h0100 : 16'h0010);
            mem_ready = 1'b1; mem_rdata = mem_rd(mem_addr);
            @(posedge clk); #1; mem_ready = 1'b0;
            chk($sformatf("rr%0d_resp_noack", k), {i_ack, d_ack}, 2'b00);
            @(posedge clk); #1;
            chk($sformatf("rr%0d_ack", k), {i_ack, d_ack}, rr_d ? 2'b01 : 2'b10);
            chk($sformatf("rr%0d_rdata", k), rr_d ? d_rdata : i_rdata,
                rr_d ? 32'hDEADBEEF : 32'h20010004);
        end
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;

        // Reset during an access: leave last_grant at I first, then abort a D access
        do_access(vecs[7], "pre_rst");
        d_req = 1'b1; d_rnw = 1'b1; d_addr = 16'h0200;
        @(posedge clk); #1;
        chk("abort_en", mem_en, 1);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("abort_en_drop", mem_en, 0);
        chk("abort_outs", {i_ack, i_rdata, i_err, d_ack, d_rdata, d_err, mem_addr}, 0);
        i_req = 1'b1; i_addr = 16'h0030;
        @(posedge clk); #1;
        chk("abort_no_ack", {i_ack, d_ack, mem_en}, 3'b000);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_en", mem_en, 1);
        chk("post_rst_fetch_first", mem_addr, 16'h0030);
        chk("post_rst_rnw", mem_rnw, 1);
        mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
        @(posedge clk); #1; mem_ready = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ack", {i_ack, d_ack}, 2'b10);
        chk("post_rst_rdata", i_rdata, 32'h0BADF00D);
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter in front of the shared read/write memory model of the DLX test bench.
- Requester I is the instruction-fetch side and is read-only. Requester D is the load/store side and can read or write.
- It serialises accesses, drives the memory's ENABLE/READNOTWRITE/ADDRESS/write-data/DATA_READY handshake, and returns one registered response per request.
- A watchdog bounds each access; an access that never completes is answered with an error.

Parameters:
- WORD_SIZE, 32, data width in bits.
- ADDRESS_SIZE, 16, address width in bits.
- TIMEOUT, 16, maximum BUSY cycles allowed per access before the error response; must be >= 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_req  in  1  fetch request; held high until i_ack.
- i_addr  in  ADDRESS_SIZE  fetch address.
- i_ack  out  1  one-cycle pulse; i_rdata/i_err valid in this cycle.
- i_rdata  out  WORD_SIZE  fetched word.
- i_err  out  1  timeout flag, qualified by i_ack.
- d_req  in  1  data request; held high until d_ack.
- d_rnw  in  1  1 = read, 0 = write.
- d_addr  in  ADDRESS_SIZE  data address.
- d_wdata  in  WORD_SIZE  write data.
- d_ack  out  1  one-cycle pulse.
- d_rdata  out  WORD_SIZE  read data; 0 for writes.
- d_err  out  1  timeout flag, qualified by d_ack.
- mem_en  out  1  to memory ENABLE.
- mem_rnw  out  1  to memory READNOTWRITE.
- mem_addr  out  ADDRESS_SIZE  to memory ADDRESS.
- mem_wdata  out  WORD_SIZE  write data toward the memory data bus. The tristate merge onto the shared data bus lives in the bench top.
- mem_rdata  in  WORD_SIZE  read data from the memory data bus.
- mem_ready  in  1  memory DATA_READY.

Behaviour:
- All outputs are registered.
- Reset values (rst=0, asynchronous): every output 0, FSM in IDLE, last_grant=D, watchdog counter 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE with mem_en=0.
  - Exactly one request: grant that requester.
  - Both requesting: grant the requester that is not last_grant (round-robin). After reset, fetch wins the first tie.
  - On grant: latch the requester id, mem_addr, mem_rnw and mem_wdata; set mem_en=1; clear the counter; move to BUSY. For fetch, mem_rnw=1 and mem_wdata=0.
- BUSY:
  - mem_en stays 1 and the latched fields stay stable. Requester inputs are ignored; changing them mid-access has no effect.
  - Each cycle: if mem_ready=1, capture mem_rdata (0 for writes), err=0, move to RESP.
  - Otherwise, if counter == TIMEOUT-1, set rdata=0, err=1, move to RESP.
  - Otherwise, increment the counter.
- RESP:
  - mem_en=0 for exactly one cycle. This enforces an ENABLE gap so stale DATA_READY is not reused.
  - Pulse the granted ack with rdata/err. Update last_grant to the granted requester. Return to IDLE.
  - The non-granted ack is 0 and its rdata/err hold their previous values.
- Latency:
  - Request high at edge N in IDLE: mem_en=1 after edge N.
  - mem_ready high at edge M: ack high after edge M+1.
  - Minimum request-to-ack is 2 cycles. Back-to-back accesses are spaced at least 3 cycles apart.
- Requester protocol:
  - The requester must deassert req in the cycle after ack, or keep it high to issue a new access.
  - A req still high when the FSM re-enters IDLE is treated as a new request. Round-robin then grants the other side if it is pending.
- Simultaneous events:
  - mem_ready=1 on the same edge as the timeout: ready wins, err=0.
  - New requests arriving during BUSY/RESP are not lost; they are served from IDLE.
- Reset mid-access: the access is abandoned, no ack is issued, and mem_en drops immediately (asynchronously).
- Starvation bound: with both requesters continuously active, grants strictly alternate I, D, I, D.

Test Plan:
- Single fetch: i_req=1, i_addr=0x0010, memory word 0x20010004, ready on the first BUSY cycle -> mem_en=1 with mem_rnw=1, mem_addr=0x0010; i_ack pulses 2 cycles after i_req with i_rdata=0x20010004, i_err=0; mem_en=0 in the ack cycle.
- Data write then read: d_rnw=0, d_addr=0x0100, d_wdata=0xDEADBEEF -> mem_rnw=0, mem_wdata=0xDEADBEEF, d_ack with d_rdata=0. Then d_rnw=1 at the same address -> d_rdata=0xDEADBEEF.
- Contention right after reset: i_req and d_req rise together and stay high for 4 accesses -> grant order I, D, I, D; exactly one ack per RESP; acks never coincide.
- Timeout: d_req=1, mem_ready held 0 -> after TIMEOUT=16 BUSY cycles, d_ack=1, d_err=1, d_rdata=0; the next i_req is still served normally.
- Ready/timeout collision: mem_ready asserted on BUSY cycle 16 -> ack with err=0 and the captured data.
- Reset mid-access: rst=0 asynchronously during BUSY -> all outputs 0 immediately, no ack. After rst=1 with i_req and d_req both high, fetch is granted first.
